// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage in front of a word-addressed
// instruction memory that answers combinationally.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             hold PC and IF/ID register (decode not ready)
//   redirect_valid    branch/jump taken; loads redirect_target and flushes IF/ID
//   redirect_target   new PC (word address)
//   address           memory address, always equal to the current PC
//   instruction       memory read data for address
//   if_valid          IF/ID register holds a valid instruction
//   if_instruction    captured instruction word
//   if_pc             address the captured instruction came from
//   halted            fetch stopped because PC left the populated range
module fetch_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 100,
  parameter int RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic                  if_valid,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] PC_LIMIT = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT  = ADDR_WIDTH'(RESET_PC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc, pc_nxt;
  logic                    valid_nxt;
  logic [DATA_WIDTH-1:0]   instr_nxt;
  logic [ADDR_WIDTH-1:0]   ifpc_nxt;
  logic                    halted_nxt;

  // Address comes straight from the PC register, so stall/redirect never
  // reach the memory address combinationally.
  assign address = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= PC_INIT;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      halted         <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      if_valid       <= valid_nxt;
      if_instruction <= instr_nxt;
      if_pc          <= ifpc_nxt;
      halted         <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    valid_nxt  = if_valid;
    instr_nxt  = if_instruction;
    ifpc_nxt   = if_pc;
    halted_nxt = halted;

    unique case (state)
      IDLE: begin
        // Stall is ignored here; nothing is captured on this first edge.
        state_nxt = FETCH;
        if (redirect_valid) pc_nxt = redirect_target;
      end

      FETCH: begin
        // Priority: redirect > out-of-range halt > stall > normal fetch.
        if (redirect_valid) begin
          pc_nxt    = redirect_target;
          valid_nxt = 1'b0;
        end else if (pc >= PC_LIMIT) begin
          valid_nxt  = 1'b0;
          halted_nxt = 1'b1;
          state_nxt  = HALT;
        end else if (!stall) begin
          instr_nxt = instruction;
          ifpc_nxt  = pc;
          valid_nxt = 1'b1;
          pc_nxt    = pc + ADDR_WIDTH'(1);
        end
      end

      HALT: begin
        valid_nxt  = 1'b0;
        halted_nxt = 1'b1;
        if (redirect_valid) begin
          pc_nxt     = redirect_target;
          halted_nxt = 1'b0;
          state_nxt  = FETCH;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        halted;

  int unsigned n_assert;
  int unsigned n_fail;

  fetch_stage #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH (100),
    .RESET_PC  (0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .address        (address),
    .instruction    (instruction),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .halted         (halted)
  );

  // Memory model: word k holds k + 1000.
  assign instruction = address + 32'd1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cap(input logic [31:0] a);
    check("cap_valid", {31'd0, if_valid}, 32'd1);
    check("cap_pc", if_pc, a);
    check("cap_instr", if_instruction, a + 32'd1000);
    check("cap_addr", address, a + 32'd1);
  endtask

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    // Reset state
    #1;
    check("rst_addr", address, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_ifpc", if_pc, 32'd0);
    check("rst_instr", if_instruction, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // IDLE edge: no capture, PC unchanged
    step();
    check("idle_valid", {31'd0, if_valid}, 32'd0);
    check("idle_addr", address, 32'd0);

    // Sequential fetch of words 0..4
    for (int a = 0; a <= 4; a++) begin
      step();
      check_cap(32'(a));
    end

    // Stall three cycles with pc=5
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", if_pc, 32'd4);
      check("stall_addr", address, 32'd5);
      check("stall_valid", {31'd0, if_valid}, 32'd1);
    end
    stall = 1'b0;
    for (int a = 5; a <= 9; a++) begin
      step();
      check_cap(32'(a));
    end

    // Redirect to 40 at pc=10 with stall also high
    check("pre_redir_addr", address, 32'd10);
    redirect_valid  = 1'b1;
    redirect_target = 32'd40;
    stall           = 1'b1;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check("redir_addr", address, 32'd40);
    check("redir_valid", {31'd0, if_valid}, 32'd0);
    check("redir_ifpc_hold", if_pc, 32'd9);

    // Run to the last legal word
    for (int a = 40; a <= 99; a++) begin
      step();
      check_cap(32'(a));
    end

    // Halt at pc=100, held across several cycles with stall toggling
    step();
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, if_valid}, 32'd0);
    check("halt_addr", address, 32'd100);
    for (int i = 0; i < 3; i++) begin
      stall = (i == 1);
      step();
      check("halt_hold_addr", address, 32'd100);
      check("halt_hold_flag", {31'd0, halted}, 32'd1);
      check("halt_hold_valid", {31'd0, if_valid}, 32'd0);
    end
    stall = 1'b0;

    // Leave HALT via redirect to 3
    redirect_valid  = 1'b1;
    redirect_target = 32'd3;
    step();
    redirect_valid = 1'b0;
    check("unhalt_flag", {31'd0, halted}, 32'd0);
    check("unhalt_addr", address, 32'd3);
    check("unhalt_valid", {31'd0, if_valid}, 32'd0);
    step();
    check_cap(32'd3);

    // Redirect out of range: one FETCH cycle at 150, then HALT
    redirect_valid  = 1'b1;
    redirect_target = 32'd150;
    step();
    redirect_valid = 1'b0;
    check("oor_addr", address, 32'd150);
    check("oor_halted0", {31'd0, halted}, 32'd0);
    check("oor_valid0", {31'd0, if_valid}, 32'd0);
    step();
    check("oor_halted1", {31'd0, halted}, 32'd1);
    check("oor_valid1", {31'd0, if_valid}, 32'd0);
    check("oor_ifpc", if_pc, 32'd3);
    check("oor_addr1", address, 32'd150);
    step();
    check("oor_ifpc2", if_pc, 32'd3);
    check("oor_valid2", {31'd0, if_valid}, 32'd0);

    // Redirect to 50, run until pc=57 with if_valid=1
    redirect_valid  = 1'b1;
    redirect_target = 32'd50;
    step();
    redirect_valid = 1'b0;
    check("r50_halted", {31'd0, halted}, 32'd0);
    check("r50_addr", address, 32'd50);
    for (int a = 50; a <= 56; a++) begin
      step();
      check_cap(32'(a));
    end

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, if_valid}, 32'd0);
    check("arst_halted", {31'd0, halted}, 32'd0);
    check("arst_addr", address, 32'd0);
    check("arst_ifpc", if_pc, 32'd0);
    step();
    check("arst_hold_addr", address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("restart_idle_valid", {31'd0, if_valid}, 32'd0);
    check("restart_idle_addr", address, 32'd0);
    step();
    check_cap(32'd0);
    step();
    check_cap(32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
